cu_seq: RTL

//   Sequential, parametrised compute unit: single-cycle ALU ops plus an iterative shift-add multiplier.

---
 rtl/cu_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cu_seq.sv
// cu_seq: sequential compute unit with single-cycle ALU ops and an iterative shift-add multiplier behind valid/ready handshakes.
// Optional feature macro CU_MULH_EN: when defined, op 110 executes MULH; otherwise op 110 is treated as reserved.
module cu_seq #(
  parameter int WIDTH    = 16,
  parameter int MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       fls,
  output logic             err
);
  localparam int ITER = WIDTH / MUL_STEP;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
`ifdef CU_MULH_EN
  localparam logic [2:0] OP_MULH = 3'b110;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r, state_nxt_s;
  logic               in_ready_r, out_valid_r, err_r;
  logic [WIDTH-1:0]   result_r, mplier_r;
  logic [3:0]         fls_r;
  logic [2*WIDTH-1:0] mcand_r, acc_r, partial_s, acc_nxt_s;
  logic [CW-1:0]      cnt_r;
`ifdef CU_MULH_EN
  logic               mulh_r;
`endif
  logic               accept_s, is_mul_s, last_s;
  logic [WIDTH:0]     sum_s, diff_s;
  logic [WIDTH-1:0]   alu_res_s, mul_res_s;
  logic [3:0]         alu_fls_s, mul_fls_s;
  logic               alu_err_s;

  function automatic logic [3:0] mk_fls(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {(r == {WIDTH{1'b0}}), r[WIDTH-1], c, v};
  endfunction

  assign accept_s = in_valid & in_ready_r;
  assign last_s   = (cnt_r == CW'(ITER - 1));
`ifdef CU_MULH_EN
  assign is_mul_s = (op == OP_MUL) || (op == OP_MULH);
`else
  assign is_mul_s = (op == OP_MUL);
`endif

  // Single-cycle ALU result and flags, computed from the operands being accepted
  always_comb begin
    sum_s     = {1'b0, op1} + {1'b0, op2};
    diff_s    = {1'b0, op1} - {1'b0, op2};
    alu_res_s = {WIDTH{1'b0}};
    alu_fls_s = 4'b1000;
    alu_err_s = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_fls_s = mk_fls(sum_s[WIDTH-1:0], sum_s[WIDTH],
                           (op1[WIDTH-1] == op2[WIDTH-1]) && (sum_s[WIDTH-1] != op1[WIDTH-1]));
      end
      OP_SUB: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_fls_s = mk_fls(diff_s[WIDTH-1:0], diff_s[WIDTH],
                           (op1[WIDTH-1] != op2[WIDTH-1]) && (diff_s[WIDTH-1] != op1[WIDTH-1]));
      end
      OP_AND: begin
        alu_res_s = op1 & op2;
        alu_fls_s = mk_fls(op1 & op2, 1'b0, 1'b0);
      end
      OP_OR: begin
        alu_res_s = op1 | op2;
        alu_fls_s = mk_fls(op1 | op2, 1'b0, 1'b0);
      end
      OP_XOR: begin
        alu_res_s = op1 ^ op2;
        alu_fls_s = mk_fls(op1 ^ op2, 1'b0, 1'b0);
      end
      OP_MUL:  alu_err_s = 1'b0;
`ifdef CU_MULH_EN
      OP_MULH: alu_err_s = 1'b0;
`endif
      default: alu_err_s = 1'b1;
    endcase
  end

  // One multiplier step: add MUL_STEP shifted partial products into the accumulator
  always_comb begin
    partial_s = {(2*WIDTH){1'b0}};
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_r[j]) begin
        partial_s = partial_s + (mcand_r << j);
      end else begin
        partial_s = partial_s;
      end
    end
    acc_nxt_s = acc_r + partial_s;
    mul_res_s = acc_nxt_s[WIDTH-1:0];
    mul_fls_s = mk_fls(acc_nxt_s[WIDTH-1:0], |acc_nxt_s[2*WIDTH-1:WIDTH], |acc_nxt_s[2*WIDTH-1:WIDTH]);
`ifdef CU_MULH_EN
    if (mulh_r) begin
      mul_res_s = acc_nxt_s[2*WIDTH-1:WIDTH];
      mul_fls_s = mk_fls(acc_nxt_s[2*WIDTH-1:WIDTH], 1'b0, 1'b0);
    end else begin
      mul_res_s = acc_nxt_s[WIDTH-1:0];
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = is_mul_s ? MULT : DONE;
        else          state_nxt_s = IDLE;
      end
      MULT: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = MULT;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Operand capture, multiplier iteration and result registers (held through DONE)
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r <= {WIDTH{1'b0}};
      fls_r    <= 4'b0000;
      err_r    <= 1'b0;
      mcand_r  <= {(2*WIDTH){1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
`ifdef CU_MULH_EN
      mulh_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      mcand_r  <= {{WIDTH{1'b0}}, op1};
      mplier_r <= op2;
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
`ifdef CU_MULH_EN
      mulh_r   <= (op == OP_MULH);
`endif
      if (!is_mul_s) begin
        result_r <= alu_res_s;
        fls_r    <= alu_fls_s;
        err_r    <= alu_err_s;
      end
    end else if (state_r == MULT) begin
      mcand_r  <= mcand_r << MUL_STEP;
      mplier_r <= mplier_r >> MUL_STEP;
      acc_r    <= acc_nxt_s;
      cnt_r    <= cnt_r + CW'(1);
      if (last_s) begin
        result_r <= mul_res_s;
        fls_r    <= mul_fls_s;
        err_r    <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign fls       = fls_r;
  assign err       = err_r;
endmodule
